// File: rtl/coprocessor_pio_master.sv
// coprocessor_pio_master
//
// Avalon-MM initiator for the Nios-side PIO register pair. It takes single
// commands (write, read, poll-until-match) from coprocessor logic and runs the
// bus cycles for each one. Every command gets exactly one response.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only when idle)
//   cmd_op                00 write, 01 read, 10 poll, 11 reserved (BAD_OP)
//   cmd_addr              target word address
//   cmd_wdata             write data, or the poll compare value
//   cmd_mask              poll compare mask
//   cmd_timeout           maximum number of poll read attempts (0 acts as 1)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              write: echoed wdata; read/poll: last captured readdata
//   rsp_status            00 OK, 01 TIMEOUT, 10 BAD_OP
//   avm_*                 registered Avalon-MM initiator signals
//   busy                  high whenever a command is in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command; cmd_ready high
// WRITE     | single bus write cycle (chipselect=1, write_n=0)
// RD_ADDR   | read address phase (chipselect=1, write_n=1); counts attempt
// RD_WAIT   | wait READ_LATENCY cycles, capture readdata on the last one
// RESP      | response held on rsp_* until rsp_ready
module coprocessor_pio_master #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  input  logic [DATA_W-1:0]    cmd_mask,
  input  logic [TIMEOUT_W-1:0] cmd_timeout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [1:0]           rsp_status,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [DATA_W-1:0]    avm_writedata,
  input  logic [DATA_W-1:0]    avm_readdata,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BAD_OP  = 2'b10;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  // Down-counter for the read wait; loaded with READ_LATENCY-1 and the
  // capture happens when it reaches zero.
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY - 1);

  logic [2:0]           state;
  logic                 poll_q;
  logic [DATA_W-1:0]    mask_q;
  logic [TIMEOUT_W:0]   limit_q;
  logic [TIMEOUT_W:0]   attempts;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 poll_hit;

  // avm_writedata holds the latched wdata for the whole command, so it
  // doubles as the poll compare value.
  assign poll_hit  = ((avm_readdata ^ avm_writedata) & mask_q) == '0;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      poll_q         <= 1'b0;
      mask_q         <= '0;
      limit_q        <= '0;
      attempts       <= '0;
      wait_cnt       <= '0;
      rsp_data       <= '0;
      rsp_status     <= ST_OK;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            avm_address   <= cmd_addr;
            avm_writedata <= cmd_wdata;
            mask_q        <= cmd_mask;
            poll_q        <= (cmd_op == OP_POLL);
            limit_q       <= (cmd_timeout == '0) ? (TIMEOUT_W+1)'(1)
                                                 : {1'b0, cmd_timeout};
            attempts      <= '0;
            case (cmd_op)
              OP_WRITE: begin
                state          <= S_WRITE;
                avm_chipselect <= 1'b1;
                avm_write_n    <= 1'b0;
              end
              OP_READ, OP_POLL: begin
                state          <= S_RD_ADDR;
                avm_chipselect <= 1'b1;
              end
              default: begin
                state      <= S_RESP;
                rsp_data   <= '0;
                rsp_status <= ST_BAD_OP;
              end
            endcase
          end
        end

        S_WRITE: begin
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          rsp_data       <= avm_writedata;
          rsp_status     <= ST_OK;
          state          <= S_RESP;
        end

        S_RD_ADDR: begin
          avm_chipselect <= 1'b0;
          // Saturating, so the counter can never wrap back below the limit.
          if (attempts != '1)
            attempts <= attempts + 1'b1;
          wait_cnt <= WAIT_LOAD;
          state    <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            rsp_data <= avm_readdata;
            if (!poll_q || poll_hit) begin
              rsp_status <= ST_OK;
              state      <= S_RESP;
            end else if (attempts == limit_q) begin
              rsp_status <= ST_TIMEOUT;
              state      <= S_RESP;
            end else begin
              avm_chipselect <= 1'b1;
              state          <= S_RD_ADDR;
            end
          end
        end

        S_RESP: begin
          if (rsp_ready)
            state <= S_IDLE;
        end

        default: begin
          state          <= S_IDLE;
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coprocessor_pio_master.sv
module tb_coprocessor_pio_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_addr = 2'b00;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_mask = '0;
  logic [15:0] cmd_timeout = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        busy;

  coprocessor_pio_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_mask       (cmd_mask),
    .cmd_timeout    (cmd_timeout),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_status     (rsp_status),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // PIO slave model: output register at address 0, registered readback of
  // in_port at address 0 (address 1 reads 0).
  logic [31:0] out_reg = '0;
  logic [31:0] slv_rdata = '0;
  logic [31:0] in_val = '0;
  logic [31:0] in_port;
  logic        rise_mode = 1'b0;
  int          rd_cnt = 0;
  int          rd_base = 0;

  assign avm_readdata = slv_rdata;
  always_comb begin
    in_port = in_val;
    if (rise_mode) in_port = {31'b0, ((rd_cnt - rd_base) >= 3)};
  end

  always @(posedge clk) begin
    if (avm_chipselect && !avm_write_n && avm_address == 2'd0)
      out_reg <= avm_writedata;
    if (avm_chipselect && avm_write_n) begin
      rd_cnt    <= rd_cnt + 1;
      slv_rdata <= (avm_address == 2'd0) ? in_port : 32'h0;
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d] actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [15:0] tmo;
    logic [31:0] inp;
    logic        rise;
    logic [1:0]  exp_st;
    logic [31:0] exp_data;
    int          exp_cyc;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [1:0] addr, logic [31:0] wdata,
                              logic [31:0] mask, logic [15:0] tmo, logic [31:0] inp,
                              logic rise, logic [1:0] exp_st, logic [31:0] exp_data,
                              int exp_cyc, int exp_rd, int exp_wr);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.mask = mask; v.tmo = tmo;
    v.inp = inp; v.rise = rise; v.exp_st = exp_st; v.exp_data = exp_data;
    v.exp_cyc = exp_cyc; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    return v;
  endfunction

  vec_t vecs[10];

  // Called #1 after a rising edge with the DUT idle. Returns after the
  // response handshake, again #1 after an edge.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, rd, wr;
    bit got;
    logic [31:0] wdat;
    in_val    = v.inp;
    rise_mode = v.rise;
    rd_base   = rd_cnt;
    chk("cmd_ready_before", idx, {31'b0, cmd_ready}, 32'd1);
    cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_mask = v.mask; cmd_timeout = v.tmo; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1; rd = 0; wr = 0; got = 0; wdat = '0;
    while (cyc <= 60 && !got) begin
      if (avm_chipselect && !avm_write_n) begin wr++; wdat = avm_writedata; end
      if (avm_chipselect && avm_write_n) rd++;
      if (rsp_valid) got = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL rsp_wait [%0d] actual=no rsp_valid required=rsp_valid within 60 cycles", idx);
    end
    chk("rsp_cycle", idx, cyc, v.exp_cyc);
    chk("rsp_status", idx, {30'b0, rsp_status}, {30'b0, v.exp_st});
    chk("rsp_data", idx, rsp_data, v.exp_data);
    chk("read_phases", idx, rd, v.exp_rd);
    chk("write_phases", idx, wr, v.exp_wr);
    if (v.exp_wr > 0) chk("writedata", idx, wdat, v.wdata);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("cmd_ready_after", idx, {31'b0, cmd_ready}, 32'd1);
    chk("rsp_valid_after", idx, {31'b0, rsp_valid}, 32'd0);
    rise_mode = 1'b0;
  endtask

  initial begin
    //               op     addr  wdata          mask          tmo    in_port        rise  st     data           cyc rd wr
    vecs[0] = mk(2'b00, 2'd0, 32'hDEADBEEF, 32'h0,        16'd0,  32'h0,        1'b0, 2'b00, 32'hDEADBEEF,  2, 0, 1);
    vecs[1] = mk(2'b01, 2'd0, 32'h0,        32'h0,        16'd0,  32'h12345678, 1'b0, 2'b00, 32'h12345678,  3, 1, 0);
    vecs[2] = mk(2'b01, 2'd1, 32'h0,        32'h0,        16'd0,  32'h12345678, 1'b0, 2'b00, 32'h00000000,  3, 1, 0);
    vecs[3] = mk(2'b10, 2'd0, 32'h1,        32'h1,        16'd10, 32'h0,        1'b1, 2'b00, 32'h00000001,  9, 4, 0);
    vecs[4] = mk(2'b10, 2'd0, 32'hAA,       32'hFF,       16'd5,  32'h55,       1'b0, 2'b01, 32'h00000055, 11, 5, 0);
    vecs[5] = mk(2'b10, 2'd0, 32'hAA,       32'hFF,       16'd0,  32'h55,       1'b0, 2'b01, 32'h00000055,  3, 1, 0);
    vecs[6] = mk(2'b10, 2'd0, 32'hA5,       32'hF0,       16'd3,  32'hAB,       1'b0, 2'b00, 32'h000000AB,  3, 1, 0);
    vecs[7] = mk(2'b11, 2'd0, 32'h12345,    32'h0,        16'd0,  32'h0,        1'b0, 2'b10, 32'h00000000,  1, 0, 0);
    vecs[8] = mk(2'b00, 2'd1, 32'h0F0F0F0F, 32'h0,        16'd0,  32'h0,        1'b0, 2'b00, 32'h0F0F0F0F,  2, 0, 1);
    vecs[9] = mk(2'b10, 2'd0, 32'hAA,       32'hFF,       16'd1,  32'h1AA,      1'b0, 2'b00, 32'h000001AA,  3, 1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 0, {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", 0, {31'b0, rsp_valid}, 32'd0);
    chk("rst_cs", 0, {31'b0, avm_chipselect}, 32'd0);
    chk("rst_write_n", 0, {31'b0, avm_write_n}, 32'd1);
    chk("rst_busy", 0, {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
      if (i == 0) chk("slave_out_reg", i, out_reg, 32'hDEADBEEF);
      if (i == 8) chk("slave_out_reg_addr1", i, out_reg, 32'hDEADBEEF);
    end

    // BAD_OP response held with rsp_ready low; a second command must wait.
    cmd_op = 2'b11; cmd_wdata = 32'h777; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 2'b00; cmd_wdata = 32'hCAFE0000;
    chk("hold_rsp_valid_c1", 0, {31'b0, rsp_valid}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", i, {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_status", i, {30'b0, rsp_status}, 32'd2);
      chk("hold_rsp_data", i, rsp_data, 32'h0);
      chk("hold_cmd_ready", i, {31'b0, cmd_ready}, 32'd0);
      chk("hold_cs", i, {31'b0, avm_chipselect}, 32'd0);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hold_release_cmd_ready", 0, {31'b0, cmd_ready}, 32'd1);
    chk("hold_release_cs", 0, {31'b0, avm_chipselect}, 32'd0);
    chk("hold_release_writedata", 0, avm_writedata, 32'h777);

    // Reset asserted during the bus write cycle.
    cmd_op = 2'b00; cmd_addr = 2'd0; cmd_wdata = 32'h11111111; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("midrst_pre_cs", 0, {31'b0, avm_chipselect}, 32'd1);
    chk("midrst_pre_write_n", 0, {31'b0, avm_write_n}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_cs", 0, {31'b0, avm_chipselect}, 32'd0);
    chk("midrst_write_n", 0, {31'b0, avm_write_n}, 32'd1);
    chk("midrst_rsp_valid", 0, {31'b0, rsp_valid}, 32'd0);
    chk("midrst_busy", 0, {31'b0, busy}, 32'd0);
    chk("midrst_cmd_ready", 0, {31'b0, cmd_ready}, 32'd1);
    chk("midrst_rsp_data", 0, rsp_data, 32'h0);
    chk("midrst_rsp_status", 0, {30'b0, rsp_status}, 32'd0);
    chk("midrst_address", 0, {30'b0, avm_address}, 32'd0);
    chk("midrst_writedata", 0, avm_writedata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_cmd_ready", 0, {31'b0, cmd_ready}, 32'd1);
    chk("postrst_busy", 0, {31'b0, busy}, 32'd0);
    chk("postrst_out_reg", 0, out_reg, 32'hDEADBEEF);

    // Normal operation after the aborted command.
    run_vec(10, vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
